// File: rtl/arm_pkg.sv
// Shared definitions for the ARM fetch pipeline: word size, bubble encoding, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_pkg;

  localparam int          WORD_BYTES   = 4;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding {PC+4, instruction, valid}.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: freeze holds contents; flush (higher priority) loads a bubble.
import arm_pkg::*;

module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  // Reset and flush both load a bubble; flush wins over freeze so a redirect is never stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_pc    <= 32'h0;
      r_instr <= BUBBLE_INSTR;
      r_valid <= 1'b0;
    end else if (!freeze) begin
      r_pc    <= pc_in;
      r_instr <= instr_in;
      r_valid <= valid_in;
    end
  end

  assign pc_out    = r_pc;
  assign instr_out = r_instr;
  assign valid_out = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, FETCH/HALT control, IF/ID register.
// Latency: imem_addr is combinational from pc; fetched word reaches IF/ID one cycle later.
// Backpressure: freeze holds pc, IF/ID and state; branch_taken overrides freeze and flushes IF/ID.
import arm_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        pc_oob
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pc_plus4;
  logic         w_pc_oob;
  logic         w_flush;
  logic         w_unused_baddr;

  assign w_pc_plus4 = r_pc + 32'(WORD_BYTES);
  assign w_pc_oob   = (r_pc >= IMEM_BYTES);
  // Redirect targets are forced word aligned, so the low bits are never consumed.
  assign w_unused_baddr = ^branch_addr[1:0];

  // PC and fetch state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= FETCH;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Next-PC / next-state selection: branch > freeze > halt hold > range check > increment.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    if (branch_taken) begin
      w_pc_nxt    = {branch_addr[31:2], 2'b00};
      w_state_nxt = FETCH;
      w_flush     = 1'b1;
    end else if (!freeze) begin
      if (r_state == HALT) begin
        w_flush = 1'b1;
      end else if (w_pc_oob) begin
        w_state_nxt = HALT;
        w_flush     = 1'b1;
      end else begin
        w_pc_nxt = w_pc_plus4;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc_oob    = (r_state == HALT);

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (w_flush),
    .pc_in     (w_pc_plus4),
    .instr_in  (imem_instr),
    .valid_in  (1'b1),
    .pc_out    (if_id_pc),
    .instr_out (if_id_instr),
    .valid_out (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: two instances (default and wrap-around parameters),
// a per-instance reference model feeding expectation queues, and a decoupled monitor.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        halt;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        ifv;
  } m_t;

  localparam logic [31:0] RP0 = 32'h0000_0000;
  localparam logic [31:0] IM0 = 32'd1024;
  localparam logic [31:0] RP1 = 32'hFFFF_FFFC;
  localparam logic [31:0] IM1 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;

  logic [31:0] a0, a1, i0, i1, p0, p1, n0, n1;
  logic        v0, v1, o0, o1;

  int total = 0;
  int bad   = 0;

  m_t ms [2];
  m_t q0 [$];
  m_t q1 [$];

  always #5 clk = ~clk;

  // Memory content tagged by address so each word identifies where it came from.
  function automatic logic [31:0] tag(input logic [31:0] addr);
    return {~addr[15:0], addr[15:0]};
  endfunction

  assign i0 = tag(a0);
  assign i1 = tag(a1);

  fetch_stage #(.RESET_PC(RP0), .IMEM_BYTES(IM0)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(a0), .imem_instr(i0),
    .if_id_pc(p0), .if_id_instr(n0), .if_id_valid(v0), .pc_oob(o0));

  fetch_stage #(.RESET_PC(RP1), .IMEM_BYTES(IM1)) dut1 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(a1), .imem_instr(i1),
    .if_id_pc(p1), .if_id_instr(n1), .if_id_valid(v1), .pc_oob(o1));

  // Behavioural model: what one clock edge does to the fetch stage's visible state.
  function automatic m_t model(input m_t s, input logic r, f, b, input logic [31:0] ba,
                               input logic [31:0] rp, im);
    m_t n;
    m_t bub;
    bub = '0;
    n = s;
    if (r) begin
      n = bub;
      n.pc = rp;
    end else if (b) begin
      n = bub;
      n.pc = (ba / 4) * 4;
    end else if (f) begin
      n = s;
    end else if (s.halt) begin
      n = bub;
      n.pc = s.pc;
      n.halt = 1'b1;
    end else if (s.pc >= im) begin
      n = bub;
      n.pc = s.pc;
      n.halt = 1'b1;
    end else begin
      n.ifpc = s.pc + 32'd4;
      n.ifinstr = tag(s.pc);
      n.ifv = 1'b1;
      n.pc = s.pc + 32'd4;
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge state, then land just after the edge.
  task automatic step(input logic r, f, b, input logic [31:0] ba);
    #1;
    rst = r;
    freeze = f;
    branch_taken = b;
    branch_addr = ba;
    ms[0] = model(ms[0], r, f, b, ba, RP0, IM0);
    ms[1] = model(ms[1], r, f, b, ba, RP1, IM1);
    q0.push_back(ms[0]);
    q1.push_back(ms[1]);
    @(posedge clk);
    #1;
  endtask

  // Monitor: just after each edge, compare every output against the oldest pending expectation.
  initial begin
    m_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("d0.imem_addr", a0, e.pc);
        check("d0.if_id_pc", p0, e.ifpc);
        check("d0.if_id_instr", n0, e.ifinstr);
        check("d0.if_id_valid", {31'b0, v0}, {31'b0, e.ifv});
        check("d0.pc_oob", {31'b0, o0}, {31'b0, e.halt});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("d1.imem_addr", a1, e.pc);
        check("d1.if_id_pc", p1, e.ifpc);
        check("d1.if_id_instr", n1, e.ifinstr);
        check("d1.if_id_valid", {31'b0, v1}, {31'b0, e.ifv});
        check("d1.pc_oob", {31'b0, o1}, {31'b0, e.halt});
      end
    end
  end

  initial begin
    logic [31:0] ba;
    logic        r, f, b;
    @(posedge clk);
    #1;

    // Reset values and the first free-running fetches.
    step(1, 0, 0, 0);
    check("rst.imem_addr", a0, 32'h0);
    check("rst.valid", {31'b0, v0}, 32'h0);
    check("rst.oob", {31'b0, o0}, 32'h0);
    check("rst.wrap_pc", a1, 32'hFFFF_FFFC);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      check("run.if_id_pc", p0, 32'(4 * k));
      check("run.valid", {31'b0, v0}, 32'h1);
      if (k == 1) begin
        check("wrap.if_id_pc", p1, 32'h0);
        check("wrap.imem_addr", a1, 32'h0);
        check("wrap.oob", {31'b0, o1}, 32'h0);
      end
    end

    // Freeze at pc=8 for three cycles.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      check("frz.pc", a0, 32'h8);
      check("frz.if_id_pc", p0, 32'h8);
      check("frz.instr", n0, tag(32'h4));
    end
    step(0, 0, 0, 0);
    check("frz.resume", p0, 32'hC);

    // Branch with simultaneous freeze; misaligned target.
    step(0, 1, 1, 32'h0000_0103);
    check("br.pc", a0, 32'h100);
    check("br.bubble_valid", {31'b0, v0}, 32'h0);
    check("br.bubble_pc", p0, 32'h0);
    step(0, 0, 0, 0);
    check("br.next_pc", p0, 32'h104);

    // Out-of-range target halts, then a redirect recovers.
    step(0, 0, 1, 32'h400);
    step(0, 0, 0, 0);
    check("oob.flag", {31'b0, o0}, 32'h1);
    check("oob.pc", a0, 32'h400);
    step(0, 0, 0, 0);
    check("oob.bubble", {31'b0, v0}, 32'h0);
    step(0, 0, 1, 32'h10);
    check("oob.clear", {31'b0, o0}, 32'h0);
    step(0, 0, 0, 0);
    check("oob.resume", p0, 32'h14);

    // Reset during freeze and during halt.
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("rstfrz.pc", a0, 32'h0);
    check("rstfrz.valid", {31'b0, v0}, 32'h0);
    step(0, 0, 1, 32'h7FC);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rsthalt.oob", {31'b0, o0}, 32'h0);
    check("rsthalt.pc", a0, 32'h0);

    // Randomized traffic, targets spanning in-range, boundary and out-of-range addresses.
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 49) == 0);
      f  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 9) == 0);
      ba = $urandom_range(0, 1279);
      if ($urandom_range(0, 15) == 0) ba = $urandom;
      step(r, f, b, ba);
    end

    #4;
    check("queue0.drained", q0.size(), 32'h0);
    check("queue1.drained", q1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
